ddr_axi_rw_arbiter: RTL and testbench
=====================================

// Module: ddr_axi_rw_arbiter
// PURPOSE
//  Shares the single DDR controller AXI port 0 (combined A channel, ATYPE 1=write/0=read) between a write
//  requester (sensor frame writer) and a read requester (LCD frame reader). Arbitrates burst requests,
//  sequences A -> W -> B for writes, tracks outstanding reads and routes R data back.
//  Sits between the frame-buffer logic and the DdrCtrl_*_0 top-level ports, in the Axi0Clk domain.
// PARAMETERS
//  ADDR_W      32     AXI byte address width
//  DATA_W      128    AXI data width; STRB width = DATA_W/8
//  MAX_RD_OUT  4      max read bursts in flight (address accepted, RLAST not yet seen)
//  WR_ID       8'h00  AID/WID used for writes
//  RD_ID       8'h01  AID used for reads
// PORTS
//  Axi0Clk        in   1        clock
//  rst_n          in   1        asynchronous reset, active low
//  wr_req/rd_req  in   1        burst request; held high with addr/len stable until matching grant pulse
//  wr_addr/rd_addr in  ADDR_W   burst start byte address (16-byte aligned)
//  wr_len/rd_len  in   8        burst beats minus 1 (AXI ALEN encoding)
//  rd_urgent      in   1        reader FIFO low; read wins a simultaneous request
//  wr_grant/rd_grant out 1      one-cycle pulse on A-channel handshake of that request
//  wr_data/wr_strb in  DATA_W/DATA_W/8  write beat payload
//  wr_data_valid  in   1        write beat valid
//  wr_data_ready  out  1        write beat accepted when valid&ready
//  wr_done        out  1        one-cycle pulse on B handshake
//  rd_data        out  DATA_W   read beat (= RDATA); no back-pressure, reader must sink every beat
//  rd_data_valid/rd_data_last out 1  RVALID / RVALID&RLAST
//  rd_err         out  1        sticky: any RRESP!=0; cleared only by reset
//  DdrCtrl_A*_0   out  -        AADDR,ALEN,ATYPE,AVALID,AID; ABURST=INCR, ASIZE=16B, ALOCK=0 constant
//  DdrCtrl_AREADY_0 in 1        A-channel ready
//  DdrCtrl_W*_0   out  -        WDATA,WSTRB,WVALID,WLAST,WID(=WR_ID); DdrCtrl_WREADY_0 in
//  DdrCtrl_BVALID_0/BID_0 in    write response; DdrCtrl_BREADY_0 out
//  DdrCtrl_R*_0   in   -        RDATA,RID,RLAST,RRESP,RVALID; DdrCtrl_RREADY_0 out, tied 1
// BEHAVIOUR
//  Reset: state IDLE, AVALID=WVALID=BREADY=0, grants/wr_done=0, rd_out_cnt=0, last_grant=RD, rd_err=0.
//  States IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR.
//  IDLE: rd_ok = rd_req & (rd_out_cnt<MAX_RD_OUT). Only wr_req -> WR_ADDR; only rd_ok -> RD_ADDR;
//   both -> RD_ADDR if rd_urgent, else the side not in last_grant (round-robin). addr/len latched on entry.
//  WR_ADDR/RD_ADDR: AVALID=1, AADDR/ALEN/ATYPE/AID stable until AREADY. On AVALID&AREADY: grant pulse
//   same cycle, last_grant updated; write -> WR_DATA (beat_cnt=0), read -> IDLE, rd_out_cnt+1.
//   Min 1 cycle IDLE->A valid; back-to-back reads issue every 2 cycles.
//  WR_DATA: WVALID=wr_data_valid, wr_data_ready=WREADY (combinational pass), WLAST=(beat_cnt==len).
//   beat_cnt++ per handshake; handshake with WLAST -> WR_RESP. Gaps in wr_data_valid allowed.
//  WR_RESP: BREADY=1; on BVALID -> wr_done pulse, IDLE. Next arbitration earliest cycle after.
//  Reads never issue during WR_ADDR..WR_RESP; R beats continue to flow during writes.
//  rd_out_cnt: +1 on read A handshake, -1 on RVALID&RLAST; both same cycle -> unchanged; saturates
//   at MAX_RD_OUT by construction (rd_ok gate). Single RD_ID -> R returns in order, no reordering.
//  wr_len=0 -> single beat, WLAST on first beat. rd_len up to 255 supported.
//  Reset asserted mid-burst: all outputs return to reset values immediately; controller itself is
//   reset by the same domain, outstanding transactions are discarded.
// STRUCTURE
//  Package ddr_axi_pkg: ATYPE_WR=1, ATYPE_RD=0, BURST_INCR=2'b01, SIZE_16B=3'b100, state enum.
//  Single module, no sub-modules; arbiter, beat counter and rd_out counter inline.
// TESTING
//  1. wr_req addr 0x1000 len 7, WREADY/AREADY=1 -> AADDR=0x1000 ATYPE=1 ALEN=7, 8 W beats, WLAST on 8th, wr_done after BVALID.
//  2. wr_req & rd_req same cycle, rd_urgent=0, last_grant=RD -> write first; repeat -> read first (alternates).
//  3. Both requesting, rd_urgent=1 -> rd_grant first regardless of last_grant.
//  4. rd_req held, no R returned, MAX_RD_OUT=4 -> exactly 4 rd_grant pulses, then stall; one RLAST -> 5th issued.
//  5. AREADY held low 10 cycles -> AVALID/AADDR stable 10 cycles, no grant until AREADY; wr_data_valid gaps -> WLAST only on beat len.
//  6. RRESP=2'b10 on one beat -> rd_err set and stays 1; rst_n low mid WR_DATA -> WVALID=0 at once, state IDLE.

Source files
------------

// File: rtl/ddr_axi_pkg.sv
// Shared constants and types for the DDR AXI port-0 read/write arbiter.
//  ATYPE_WR / ATYPE_RD : combined A-channel direction encoding
//  BURST_INCR          : ABURST encoding for incrementing bursts
//  SIZE_16B            : ASIZE encoding for 16-byte beats
//  arb_state_e         : arbiter / channel-sequencing FSM states
package ddr_axi_pkg;

  localparam logic       ATYPE_WR   = 1'b1;
  localparam logic       ATYPE_RD   = 1'b0;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_16B   = 3'b100;

  typedef enum logic [2:0] {
    StIdle,
    StWrAddr,
    StWrData,
    StWrResp,
    StRdAddr
  } arb_state_e;

endpackage

// File: rtl/ddr_axi_rw_arbiter.sv
// Shares DDR controller AXI port 0 (combined A channel) between a frame writer and a frame
// reader. Arbitrates burst requests, sequences A -> W -> B for writes, counts outstanding
// read bursts and forwards R beats to the reader.
// Ports:
//  Axi0Clk, rst_n             clock, asynchronous active-low reset
//  wr_req/wr_addr/wr_len      write burst request (held until wr_grant)
//  rd_req/rd_addr/rd_len      read burst request (held until rd_grant)
//  rd_urgent                  reader FIFO low: read wins a simultaneous request
//  wr_grant/rd_grant          one-cycle pulse on the A-channel handshake
//  wr_data/wr_strb/wr_data_valid/wr_data_ready   write beat stream
//  wr_done                    one-cycle pulse on the B handshake
//  rd_data/rd_data_valid/rd_data_last            read beat stream, no back-pressure
//  rd_err                     sticky flag, set by any non-OKAY RRESP
//  DdrCtrl_*_0                controller AXI port 0 (A, W, B, R channels)
module ddr_axi_rw_arbiter
  import ddr_axi_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned MAX_RD_OUT = 4,
  parameter logic [7:0]  WR_ID      = 8'h00,
  parameter logic [7:0]  RD_ID      = 8'h01
) (
  input  logic                  Axi0Clk,
  input  logic                  rst_n,
  // requesters
  input  logic                  wr_req,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [7:0]            wr_len,
  input  logic                  rd_req,
  input  logic [ADDR_W-1:0]     rd_addr,
  input  logic [7:0]            rd_len,
  input  logic                  rd_urgent,
  output logic                  wr_grant,
  output logic                  rd_grant,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_strb,
  input  logic                  wr_data_valid,
  output logic                  wr_data_ready,
  output logic                  wr_done,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_data_valid,
  output logic                  rd_data_last,
  output logic                  rd_err,
  // controller A channel
  output logic [ADDR_W-1:0]     DdrCtrl_AADDR_0,
  output logic [7:0]            DdrCtrl_ALEN_0,
  output logic                  DdrCtrl_ATYPE_0,
  output logic                  DdrCtrl_AVALID_0,
  output logic [7:0]            DdrCtrl_AID_0,
  output logic [1:0]            DdrCtrl_ABURST_0,
  output logic [2:0]            DdrCtrl_ASIZE_0,
  output logic [1:0]            DdrCtrl_ALOCK_0,
  input  logic                  DdrCtrl_AREADY_0,
  // controller W channel
  output logic [DATA_W-1:0]     DdrCtrl_WDATA_0,
  output logic [DATA_W/8-1:0]   DdrCtrl_WSTRB_0,
  output logic                  DdrCtrl_WVALID_0,
  output logic                  DdrCtrl_WLAST_0,
  output logic [7:0]            DdrCtrl_WID_0,
  input  logic                  DdrCtrl_WREADY_0,
  // controller B channel
  input  logic                  DdrCtrl_BVALID_0,
  input  logic [7:0]            DdrCtrl_BID_0,
  output logic                  DdrCtrl_BREADY_0,
  // controller R channel
  input  logic [DATA_W-1:0]     DdrCtrl_RDATA_0,
  input  logic [7:0]            DdrCtrl_RID_0,
  input  logic                  DdrCtrl_RLAST_0,
  input  logic [1:0]            DdrCtrl_RRESP_0,
  input  logic                  DdrCtrl_RVALID_0,
  output logic                  DdrCtrl_RREADY_0
);

  localparam int unsigned CntW = $clog2(MAX_RD_OUT + 1);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [7:0]        beat_cnt_q;
  logic [CntW-1:0]   rd_out_cnt_q;
  logic              last_wr_q;  // 1: most recent grant went to the writer
  logic              rd_err_q;

  logic rd_ok, pick_wr, pick_rd;
  logic a_hs, w_hs, w_last, rd_dec;

  // Single IDs on each side: B/R ordering is implicit, so the IDs carry no information here.
  logic unused_ids;
  assign unused_ids = ^{DdrCtrl_BID_0, DdrCtrl_RID_0};

  assign rd_ok  = rd_req && (rd_out_cnt_q < CntW'(MAX_RD_OUT));
  assign a_hs   = DdrCtrl_AVALID_0 && DdrCtrl_AREADY_0;
  assign w_hs   = DdrCtrl_WVALID_0 && DdrCtrl_WREADY_0;
  assign w_last = (beat_cnt_q == len_q);
  // Guard keeps a stray RLAST from wrapping the counter below zero.
  assign rd_dec = DdrCtrl_RVALID_0 && DdrCtrl_RLAST_0 && (rd_out_cnt_q != '0);

  // Arbitration: urgent read wins, otherwise round-robin against the last grant.
  always_comb begin
    pick_wr = 1'b0;
    pick_rd = 1'b0;
    if (wr_req && rd_ok) begin
      if (rd_urgent || last_wr_q) pick_rd = 1'b1;
      else                        pick_wr = 1'b1;
    end else if (wr_req) begin
      pick_wr = 1'b1;
    end else if (rd_ok) begin
      pick_rd = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge Axi0Clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (pick_wr)      state_d = StWrAddr;
        else if (pick_rd) state_d = StRdAddr;
      end
      StWrAddr: if (DdrCtrl_AREADY_0)  state_d = StWrData;
      StWrData: if (w_hs && w_last)    state_d = StWrResp;
      StWrResp: if (DdrCtrl_BVALID_0)  state_d = StIdle;
      StRdAddr: if (DdrCtrl_AREADY_0)  state_d = StIdle;
      default:                         state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    DdrCtrl_AVALID_0 = 1'b0;
    DdrCtrl_ATYPE_0  = ATYPE_RD;
    DdrCtrl_AID_0    = RD_ID;
    DdrCtrl_WVALID_0 = 1'b0;
    DdrCtrl_WLAST_0  = 1'b0;
    DdrCtrl_BREADY_0 = 1'b0;
    wr_data_ready    = 1'b0;
    wr_grant         = 1'b0;
    rd_grant         = 1'b0;
    wr_done          = 1'b0;
    unique case (state_q)
      StWrAddr: begin
        DdrCtrl_AVALID_0 = 1'b1;
        DdrCtrl_ATYPE_0  = ATYPE_WR;
        DdrCtrl_AID_0    = WR_ID;
        wr_grant         = DdrCtrl_AREADY_0;
      end
      StRdAddr: begin
        DdrCtrl_AVALID_0 = 1'b1;
        rd_grant         = DdrCtrl_AREADY_0;
      end
      StWrData: begin
        DdrCtrl_WVALID_0 = wr_data_valid;
        DdrCtrl_WLAST_0  = w_last;
        wr_data_ready    = DdrCtrl_WREADY_0;
      end
      StWrResp: begin
        DdrCtrl_BREADY_0 = 1'b1;
        wr_done          = DdrCtrl_BVALID_0;
      end
      default: ;
    endcase
  end

  // Burst descriptor latch, beat counter and round-robin history.
  always_ff @(posedge Axi0Clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      last_wr_q  <= 1'b0;
    end else begin
      if (state_q == StIdle) begin
        if (pick_wr) begin
          addr_q <= wr_addr;
          len_q  <= wr_len;
        end else if (pick_rd) begin
          addr_q <= rd_addr;
          len_q  <= rd_len;
        end
      end
      if (a_hs) begin
        last_wr_q  <= (state_q == StWrAddr);
        beat_cnt_q <= '0;
      end else if (w_hs) begin
        beat_cnt_q <= beat_cnt_q + 8'd1;
      end
    end
  end

  // Outstanding read bursts and sticky read error.
  always_ff @(posedge Axi0Clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_out_cnt_q <= '0;
      rd_err_q     <= 1'b0;
    end else begin
      unique case ({rd_grant, rd_dec})
        2'b10:   rd_out_cnt_q <= rd_out_cnt_q + 1'b1;
        2'b01:   rd_out_cnt_q <= rd_out_cnt_q - 1'b1;
        default: ;
      endcase
      if (DdrCtrl_RVALID_0 && (DdrCtrl_RRESP_0 != 2'b00)) rd_err_q <= 1'b1;
    end
  end

  assign DdrCtrl_AADDR_0  = addr_q;
  assign DdrCtrl_ALEN_0   = len_q;
  assign DdrCtrl_ABURST_0 = BURST_INCR;
  assign DdrCtrl_ASIZE_0  = SIZE_16B;
  assign DdrCtrl_ALOCK_0  = 2'b00;
  assign DdrCtrl_WDATA_0  = wr_data;
  assign DdrCtrl_WSTRB_0  = wr_strb;
  assign DdrCtrl_WID_0    = WR_ID;
  assign DdrCtrl_RREADY_0 = 1'b1;

  assign rd_data       = DdrCtrl_RDATA_0;
  assign rd_data_valid = DdrCtrl_RVALID_0;
  assign rd_data_last  = DdrCtrl_RVALID_0 && DdrCtrl_RLAST_0;
  assign rd_err        = rd_err_q;

endmodule

// File: tb/tb_ddr_axi_rw_arbiter.sv
// Bench for ddr_axi_rw_arbiter: requester drivers, a simple DDR controller responder and a
// transaction-level model (expected A-channel order, write burst progress, outstanding read
// count, sticky error) checked every cycle, plus hand-computed per-test expectations.
module tb_ddr_axi_rw_arbiter;

  localparam int MaxRdOut = 4;

  logic         clk, rst_n;
  logic         wr_req, rd_req, rd_urgent;
  logic [31:0]  wr_addr, rd_addr;
  logic [7:0]   wr_len, rd_len;
  logic         wr_grant, rd_grant;
  logic [127:0] wr_data;
  logic [15:0]  wr_strb;
  logic         wr_data_valid, wr_data_ready, wr_done;
  logic [127:0] rd_data;
  logic         rd_data_valid, rd_data_last, rd_err;
  logic [31:0]  a_addr;
  logic [7:0]   a_len, a_id;
  logic         a_type, a_valid, a_ready;
  logic [1:0]   a_burst, a_lock;
  logic [2:0]   a_size;
  logic [127:0] w_data;
  logic [15:0]  w_strb;
  logic         w_valid, w_last, w_ready;
  logic [7:0]   w_id, b_id, r_id;
  logic         b_valid, b_ready;
  logic [127:0] r_data;
  logic         r_last, r_valid, r_ready;
  logic [1:0]   r_resp;

  ddr_axi_rw_arbiter #(.MAX_RD_OUT(MaxRdOut)) dut (
    .Axi0Clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_urgent(rd_urgent),
    .wr_grant(wr_grant), .rd_grant(rd_grant),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_data_valid(wr_data_valid),
    .wr_data_ready(wr_data_ready), .wr_done(wr_done),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_last(rd_data_last),
    .rd_err(rd_err),
    .DdrCtrl_AADDR_0(a_addr), .DdrCtrl_ALEN_0(a_len), .DdrCtrl_ATYPE_0(a_type),
    .DdrCtrl_AVALID_0(a_valid), .DdrCtrl_AID_0(a_id), .DdrCtrl_ABURST_0(a_burst),
    .DdrCtrl_ASIZE_0(a_size), .DdrCtrl_ALOCK_0(a_lock), .DdrCtrl_AREADY_0(a_ready),
    .DdrCtrl_WDATA_0(w_data), .DdrCtrl_WSTRB_0(w_strb), .DdrCtrl_WVALID_0(w_valid),
    .DdrCtrl_WLAST_0(w_last), .DdrCtrl_WID_0(w_id), .DdrCtrl_WREADY_0(w_ready),
    .DdrCtrl_BVALID_0(b_valid), .DdrCtrl_BID_0(b_id), .DdrCtrl_BREADY_0(b_ready),
    .DdrCtrl_RDATA_0(r_data), .DdrCtrl_RID_0(r_id), .DdrCtrl_RLAST_0(r_last),
    .DdrCtrl_RRESP_0(r_resp), .DdrCtrl_RVALID_0(r_valid), .DdrCtrl_RREADY_0(r_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [127:0] beat_pat(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = a + 32'(n);
    return {4{w}};
  endfunction

  // ---------------- model state ----------------
  typedef struct packed {
    logic        typ;  // 1 = write
    logic [31:0] addr;
    logic [7:0]  len;
  } a_exp_t;

  a_exp_t exp_q[$];
  int          phase = 0;  // 0 no write burst, 1 data beats, 2 awaiting response
  int          beat = 0;
  logic [7:0]  cur_len = 0;
  int          rd_out_m = 0;
  logic        err_m = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = 0;
  logic [7:0]  prev_len = 0;
  logic        prev_type = 1'b0;
  int wr_gnt_n = 0, rd_gnt_n = 0, w_beat_n = 0, wlast_n = 0, wr_done_n = 0;
  int wlast_beat_no = 0;
  logic [31:0] last_a_addr = 0;
  logic [7:0]  last_a_len = 0;
  logic        last_a_type = 1'b0;
  logic        gnt_log[$];

  // Compare process: outputs are checked at every negedge against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_avalid", a_valid, 0);
        chk("rst_wvalid", w_valid, 0);
        chk("rst_bready", b_ready, 0);
        chk("rst_grants", {wr_grant, rd_grant, wr_done}, 0);
        chk("rst_rd_err", rd_err, 0);
        phase = 0; rd_out_m = 0; err_m = 1'b0; prev_stall = 1'b0;
        exp_q.delete();
      end else begin
        chk("rd_data", rd_data, r_data);
        chk("rd_valid", rd_data_valid, r_valid);
        chk("rd_last", rd_data_last, r_valid & r_last);
        chk("rready", r_ready, 1);
        chk("rd_err", rd_err, err_m);
        chk("wid", w_id, 8'h00);
        chk("wr_grant", wr_grant, a_valid & a_ready & a_type);
        chk("rd_grant", rd_grant, a_valid & a_ready & ~a_type);
        if (a_valid) begin
          chk("a_burst", a_burst, 2'b01);
          chk("a_size", a_size, 3'b100);
          chk("a_lock", a_lock, 0);
          chk("a_id", a_id, a_type ? 8'h00 : 8'h01);
          chk("a_during_write", phase, 0);
          if (!a_type) chk("rd_out_limit", rd_out_m < MaxRdOut, 1);
        end
        if (prev_stall) begin
          chk("a_hold_valid", a_valid, 1);
          chk("a_hold_addr", a_addr, prev_addr);
          chk("a_hold_len", a_len, prev_len);
          chk("a_hold_type", a_type, prev_type);
        end
        // write channel progress
        if (phase == 1) begin
          chk("w_valid", w_valid, wr_data_valid);
          chk("w_ready_pass", wr_data_ready, w_ready);
          chk("b_ready_data", b_ready, 0);
          chk("wr_done_data", wr_done, 0);
          if (w_valid) begin
            chk("w_last", w_last, beat == int'(cur_len));
            chk("w_data", w_data, wr_data);
            chk("w_strb", w_strb, wr_strb);
          end
          if (w_valid && w_ready) begin
            w_beat_n++;
            if (w_last) begin
              wlast_n++;
              wlast_beat_no = beat + 1;
            end
            if (beat == int'(cur_len)) phase = 2;
            else beat++;
          end
        end else if (phase == 2) begin
          chk("b_ready_resp", b_ready, 1);
          chk("wr_done", wr_done, b_valid);
          chk("w_valid_resp", w_valid, 0);
          if (b_valid) begin
            phase = 0;
            wr_done_n++;
          end
        end else begin
          chk("w_valid_idle", w_valid, 0);
          chk("w_ready_idle", wr_data_ready, 0);
          chk("b_ready_idle", b_ready, 0);
          chk("wr_done_idle", wr_done, 0);
        end
        // A-channel handshake against the expected order
        if (a_valid && a_ready) begin
          chk("a_expected", exp_q.size() != 0, 1);
          last_a_addr = a_addr; last_a_len = a_len; last_a_type = a_type;
          gnt_log.push_back(a_type);
          if (exp_q.size() != 0) begin
            a_exp_t e;
            e = exp_q.pop_front();
            chk("a_type", a_type, e.typ);
            chk("a_addr", a_addr, e.addr);
            chk("a_len", a_len, e.len);
            if (e.typ) begin
              phase = 1; beat = 0; cur_len = e.len;
            end
          end
          if (a_type) wr_gnt_n++;
          else begin
            rd_gnt_n++;
            rd_out_m++;
          end
        end
        if (r_valid && r_last) rd_out_m--;
        if (r_valid && r_resp != 2'b00) err_m = 1'b1;
        prev_stall = a_valid & ~a_ready;
        prev_addr = a_addr; prev_len = a_len; prev_type = a_type;
      end
    end
  end

  // ---------------- DDR controller responder ----------------
  logic [7:0] rd_pend[$];
  int  b_wait = 0, r_beat = 0, r_done_cnt = 0, r_bad_done = 0;
  int  r_limit = 32'h7fffffff;
  int  r_bad_req = 0;
  logic [31:0] r_seq = 32'hA5A50000;

  initial begin
    logic s_a_rd, s_wlast, s_b, s_r, s_rl;
    logic [7:0] s_len;
    b_valid = 0; b_id = 8'h00; r_valid = 0; r_last = 0; r_resp = 0; r_id = 8'h01; r_data = 0;
    forever begin
      @(negedge clk);
      s_a_rd = a_valid & a_ready & ~a_type;
      s_len = a_len;
      s_wlast = w_valid & w_ready & w_last;
      s_b = b_valid & b_ready;
      s_r = r_valid;
      s_rl = r_valid & r_last;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        b_valid = 0; r_valid = 0; r_last = 0; r_resp = 0; b_wait = 0; r_beat = 0;
        rd_pend.delete();
      end else begin
        if (s_b) b_valid = 0;
        if (s_wlast) b_wait = 2;
        else if (b_wait > 0) begin
          b_wait--;
          if (b_wait == 0) b_valid = 1;
        end
        if (s_a_rd) rd_pend.push_back(s_len);
        if (s_r) begin
          if (s_rl) begin
            void'(rd_pend.pop_front());
            r_beat = 0;
            r_done_cnt++;
          end else r_beat++;
        end
        if (rd_pend.size() > 0 && r_done_cnt < r_limit) begin
          r_valid = 1;
          r_last = (r_beat == int'(rd_pend[0]));
          r_data = {4{r_seq}};
          r_seq++;
          r_resp = 2'b00;
          if (r_bad_done < r_bad_req) begin
            r_resp = 2'b10;
            r_bad_done++;
          end
        end else begin
          r_valid = 0; r_last = 0; r_resp = 0;
        end
      end
    end
  end

  // ---------------- requester drivers ----------------
  task automatic expect_a(input logic typ, input logic [31:0] a, input logic [7:0] l);
    a_exp_t e;
    e.typ = typ; e.addr = a; e.len = l;
    exp_q.push_back(e);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] l);
    bit ok = 0;
    @(posedge clk); #1;
    rd_req = 1; rd_addr = a; rd_len = l;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (rd_grant) ok = 1;
    end
    @(posedge clk); #1;
    rd_req = 0;
    chk("rd_grant_seen", ok, 1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] l, input bit gaps);
    bit ok = 0;
    int n = 0;
    @(posedge clk); #1;
    wr_req = 1; wr_addr = a; wr_len = l;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (wr_grant) ok = 1;
    end
    @(posedge clk); #1;
    wr_req = 0;
    chk("wr_grant_seen", ok, 1);
    for (int c = 0; c < 600 && n <= int'(l); c++) begin
      wr_data_valid = gaps ? (c % 3 != 2) : 1'b1;
      wr_data = beat_pat(a, n);
      wr_strb = 16'hFFFF ^ 16'(n);
      @(negedge clk);
      if (wr_data_valid && wr_data_ready) n++;
      @(posedge clk); #1;
    end
    wr_data_valid = 0;
    chk("wr_beats_sent", n, int'(l) + 1);
    ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (wr_done) ok = 1;
    end
    chk("wr_done_seen", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int c = 0; c < 1000 && !ok; c++) begin
      @(negedge clk);
      if (phase == 0 && exp_q.size() == 0 && rd_out_m == 0 && !b_valid) ok = 1;
    end
    chk("idle_reached", ok, 1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int b0, l0, d0, g0, cnt, lat;
    bit ok;
    rst_n = 0; wr_req = 0; rd_req = 0; rd_urgent = 0; wr_addr = 0; rd_addr = 0;
    wr_len = 0; rd_len = 0; wr_data = 0; wr_strb = 0; wr_data_valid = 0;
    a_ready = 1; w_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("reset_avalid", a_valid, 0);
    chk("reset_rd_err", rd_err, 0);

    // 1: single 8-beat write
    b0 = w_beat_n; l0 = wlast_n; d0 = wr_done_n;
    expect_a(1, 32'h1000, 8'd7);
    do_write(32'h1000, 8'd7, 0);
    chk("t1_aaddr", last_a_addr, 32'h1000);
    chk("t1_alen", last_a_len, 7);
    chk("t1_atype", last_a_type, 1);
    chk("t1_beats", w_beat_n - b0, 8);
    chk("t1_wlast_cnt", wlast_n - l0, 1);
    chk("t1_wlast_beat", wlast_beat_no, 8);
    chk("t1_done", wr_done_n - d0, 1);
    wait_idle();

    // 2: round-robin on simultaneous requests
    expect_a(0, 32'h2000, 8'd3);
    do_read(32'h2000, 8'd3);
    wait_idle();
    expect_a(1, 32'h4000, 8'd1);
    expect_a(0, 32'h5000, 8'd0);
    fork
      do_write(32'h4000, 8'd1, 0);
      do_read(32'h5000, 8'd0);
    join
    wait_idle();
    chk("t2a_first_is_wr", gnt_log[gnt_log.size()-2], 1);
    chk("t2a_second_is_rd", gnt_log[gnt_log.size()-1], 0);
    expect_a(1, 32'h6000, 8'd0);
    do_write(32'h6000, 8'd0, 0);
    chk("t2_len0_wlast_beat", wlast_beat_no, 1);
    wait_idle();
    expect_a(0, 32'h7000, 8'd2);
    expect_a(1, 32'h8000, 8'd2);
    fork
      do_write(32'h8000, 8'd2, 0);
      do_read(32'h7000, 8'd2);
    join
    wait_idle();
    chk("t2b_first_is_rd", gnt_log[gnt_log.size()-2], 0);
    chk("t2b_second_is_wr", gnt_log[gnt_log.size()-1], 1);

    // 3: urgent read beats round-robin (last grant = read)
    expect_a(0, 32'h9000, 8'd0);
    do_read(32'h9000, 8'd0);
    wait_idle();
    rd_urgent = 1;
    expect_a(0, 32'hA000, 8'd2);
    expect_a(1, 32'hB000, 8'd2);
    fork
      do_write(32'hB000, 8'd2, 0);
      do_read(32'hA000, 8'd2);
    join
    rd_urgent = 0;
    wait_idle();
    chk("t3_first_is_rd", gnt_log[gnt_log.size()-2], 0);
    chk("t3_second_is_wr", gnt_log[gnt_log.size()-1], 1);

    // 4: outstanding read limit
    r_limit = r_done_cnt;
    g0 = rd_gnt_n;
    for (int i = 0; i < 5; i++) expect_a(0, 32'hC000 + 32'(i * 'h100), 8'd0);
    for (int i = 0; i < 4; i++) do_read(32'hC000 + 32'(i * 'h100), 8'd0);
    fork
      do_read(32'hC400, 8'd0);
      begin
        repeat (15) @(negedge clk);
        chk("t4_stalled_at_4", rd_gnt_n - g0, 4);
        r_limit = r_done_cnt + 1;
      end
    join
    chk("t4_fifth_issued", rd_gnt_n - g0, 5);
    r_limit = 32'h7fffffff;
    wait_idle();

    // 5: AREADY held low, then gapped write data
    a_ready = 0;
    g0 = wr_gnt_n; b0 = w_beat_n; l0 = wlast_n;
    expect_a(1, 32'hD000, 8'd3);
    fork
      do_write(32'hD000, 8'd3, 1);
      begin
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
          @(negedge clk);
          if (a_valid) ok = 1;
        end
        chk("t5_avalid_seen", ok, 1);
        cnt = 0;
        repeat (10) begin
          @(negedge clk);
          if (a_valid) cnt++;
        end
        chk("t5_avalid_held", cnt, 10);
        chk("t5_no_grant", wr_gnt_n - g0, 0);
        @(posedge clk); #1;
        a_ready = 1;
      end
    join
    chk("t5_beats", w_beat_n - b0, 4);
    chk("t5_wlast_cnt", wlast_n - l0, 1);
    chk("t5_wlast_beat", wlast_beat_no, 4);
    wait_idle();

    // 6: sticky read error, then reset in the middle of a write burst
    chk("t6_err_clear", rd_err, 0);
    r_bad_req = r_bad_req + 1;
    expect_a(0, 32'hE000, 8'd3);
    do_read(32'hE000, 8'd3);
    wait_idle();
    chk("t6_err_set", rd_err, 1);
    repeat (5) @(negedge clk);
    chk("t6_err_sticky", rd_err, 1);
    w_ready = 0;
    expect_a(1, 32'hF000, 8'd3);
    @(posedge clk); #1;
    wr_req = 1; wr_addr = 32'hF000; wr_len = 8'd3;
    ok = 0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (wr_grant) ok = 1;
    end
    chk("t6_wr_grant", ok, 1);
    @(posedge clk); #1;
    wr_req = 0; wr_data_valid = 1; wr_data = beat_pat(32'hF000, 0);
    repeat (2) @(negedge clk);
    chk("t6_wvalid_before", w_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("t6_wvalid_reset", w_valid, 0);
    chk("t6_avalid_reset", a_valid, 0);
    chk("t6_bready_reset", b_ready, 0);
    chk("t6_err_reset", rd_err, 0);
    wr_data_valid = 0; w_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // after reset: idle, and a read reaches the A channel one cycle after request
    expect_a(0, 32'h0100, 8'd0);
    @(posedge clk); #1;
    rd_req = 1; rd_addr = 32'h0100; rd_len = 8'd0;
    lat = 0; ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      lat++;
      if (rd_grant) ok = 1;
    end
    @(posedge clk); #1;
    rd_req = 0;
    chk("t7_grant_latency", lat, 2);
    wait_idle();
    chk("exp_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not complete (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

endmodule
